// File: rtl/register_reporter.sv
// rtl/register_reporter.sv - reports changes of a CPU register as hex text over an 8N1 UART
module register_reporter #(
  parameter int REGISTER_WIDTH = 32,
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] registerValue,
  output logic                      txd,
  output logic                      busy,
  output logic [15:0]               reportCount
);

  localparam int NIBBLES = REGISTER_WIDTH / 4;
  localparam int NCHARS  = NIBBLES + 2;
  localparam int CHAR_W  = $clog2(NCHARS);
  localparam int TIMER_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0]  CHAR_LAST  = CHAR_W'(NCHARS - 1);
  localparam logic [CHAR_W-1:0]  CHAR_CR    = CHAR_W'(NIBBLES);
  localparam logic [CHAR_W-1:0]  CHAR_LF    = CHAR_W'(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    r_state;
  logic [REGISTER_WIDTH-1:0] r_last_sent;
  logic [REGISTER_WIDTH-1:0] r_snapshot;
  logic [TIMER_W-1:0]        r_bit_timer;
  logic [2:0]                r_bit_idx;
  logic [CHAR_W-1:0]         r_char_idx;
  logic                      r_txd;
  logic                      r_busy;
  logic [15:0]               r_report_count;

  logic [3:0] w_nibble;
  logic [7:0] w_char;
  logic       w_bit_done;

  assign txd         = r_txd;
  assign busy        = r_busy;
  assign reportCount = r_report_count;
  assign w_bit_done  = (r_bit_timer == TIMER_LAST);

  // Character index 0 carries the most significant nibble of the snapshot.
  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_char_idx == CHAR_W'(NIBBLES - 1 - i)) w_nibble = r_snapshot[4*i +: 4];
    end
  end

  always_comb begin
    w_char = 8'h00;
    if (r_char_idx == CHAR_CR)      w_char = 8'h0D;
    else if (r_char_idx == CHAR_LF) w_char = 8'h0A;
    else if (w_nibble < 4'd10)      w_char = 8'h30 + {4'h0, w_nibble};
    else                            w_char = 8'h37 + {4'h0, w_nibble};
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      r_state        <= IDLE;
      r_last_sent    <= '0;
      r_snapshot     <= '0;
      r_bit_timer    <= '0;
      r_bit_idx      <= '0;
      r_char_idx     <= '0;
      r_txd          <= 1'b1;
      r_busy         <= 1'b0;
      r_report_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd  <= 1'b1;
          r_busy <= 1'b0;
          if (registerValue != r_last_sent) begin
            r_snapshot  <= registerValue;
            r_last_sent <= registerValue;
            r_char_idx  <= '0;
            r_bit_idx   <= '0;
            r_bit_timer <= '0;
            r_txd       <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_bit_timer <= '0;
            r_bit_idx   <= '0;
            r_txd       <= w_char[0];
            r_state     <= DATA;
          end else begin
            r_bit_timer <= r_bit_timer + TIMER_W'(1);
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_bit_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_char[r_bit_idx + 3'd1];
            end
          end else begin
            r_bit_timer <= r_bit_timer + TIMER_W'(1);
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_bit_timer <= '0;
            // Next character follows back-to-back; the LF stop bit closes the report.
            if (r_char_idx == CHAR_LAST) begin
              r_txd          <= 1'b1;
              r_busy         <= 1'b0;
              r_report_count <= r_report_count + 16'd1;
              r_state        <= IDLE;
            end else begin
              r_char_idx <= r_char_idx + CHAR_W'(1);
              r_txd      <= 1'b0;
              r_state    <= START;
            end
          end else begin
            r_bit_timer <= r_bit_timer + TIMER_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_reporter.sv
// tb/tb_register_reporter.sv - random and directed checks of register_reporter against a report-level model
module tb_register_reporter;

  localparam int W   = 16;
  localparam int CPB = 4;
  localparam int REPORT_CYCLES = (W / 4 + 2) * 10 * CPB;

  logic          clock = 1'b0;
  logic          isReset = 1'b1;
  logic [W-1:0]  registerValue = '0;
  logic          txd;
  logic          busy;
  logic [15:0]   reportCount;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  m_last = '0;
  int            m_rem = 0;
  logic [15:0]   m_count = '0;
  logic [47:0]   exp_q[$];

  logic [47:0]   rx_line = '0;
  int            rx_n = 0;

  register_reporter #(.REGISTER_WIDTH(W), .CLOCKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .isReset(isReset),
    .registerValue(registerValue),
    .txd(txd),
    .busy(busy),
    .reportCount(reportCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] hexline(input logic [W-1:0] v);
    logic [47:0] r;
    int nib;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      nib = int'((v >> (12 - 4 * i)) & 16'h000F);
      r = {r[39:0], (nib < 10) ? 8'(nib + 48) : 8'(nib + 55)};
    end
    r = {r[39:0], 8'h0D};
    r = {r[39:0], 8'h0A};
    return r;
  endfunction

  // Report-level model: a report occupies REPORT_CYCLES edges; a value differing
  // from the last reported one is picked up on any edge where no report is running.
  task automatic model_edge();
    if (isReset) return;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_count++;
    end else if (registerValue != m_last) begin
      m_last = registerValue;
      m_rem  = REPORT_CYCLES;
      exp_q.push_back(hexline(registerValue));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("busy", {47'b0, busy}, {47'b0, m_rem > 0});
    check("count", {32'b0, reportCount}, {32'b0, m_count});
    if (m_rem == 0) check("txd_idle", {47'b0, txd}, 48'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int hold);
    #1 isReset = 1'b1;
    if (m_rem > 0) void'(exp_q.pop_back());
    m_rem = 0; m_last = '0; m_count = '0;
    #1;
    check("rst_txd", {47'b0, txd}, 48'd1);
    check("rst_busy", {47'b0, busy}, 48'd0);
    check("rst_count", {32'b0, reportCount}, 48'd0);
    steps(hold);
    isReset = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * REPORT_CYCLES && m_rem > 0; i++) step();
    step();
  endtask

  // UART receiver sampling bit centres on the falling clock edge.
  initial begin
    logic [7:0] b;
    logic       abort;
    logic       start_bit;
    logic       stop_bit;
    forever begin
      @(negedge clock);
      if (isReset) rx_n = 0;
      else if (txd == 1'b0) begin
        abort = 1'b0;
        b = '0;
        for (int k = 0; k < CPB / 2; k++) begin @(negedge clock); if (isReset) abort = 1'b1; end
        start_bit = txd;
        for (int bi = 0; bi < 8; bi++) begin
          for (int k = 0; k < CPB; k++) begin @(negedge clock); if (isReset) abort = 1'b1; end
          b[bi] = txd;
        end
        for (int k = 0; k < CPB; k++) begin @(negedge clock); if (isReset) abort = 1'b1; end
        stop_bit = txd;
        if (abort || isReset) rx_n = 0;
        else begin
          check("start_bit", {47'b0, start_bit}, 48'd0);
          check("stop_bit", {47'b0, stop_bit}, 48'd1);
          rx_line = {rx_line[39:0], b};
          rx_n++;
          if (b == 8'h0A) begin
            check("line_len", 48'(rx_n), 48'd6);
            if (exp_q.size() == 0) check("unexpected_line", 48'(exp_q.size()), 48'd1);
            else check("line", rx_line, exp_q.pop_front());
            rx_n = 0;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] v;
    steps(3);
    isReset = 1'b0;

    // Zero after reset is never reported.
    steps(20);
    do_reset(3);
    steps(500);

    // Single report, busy width.
    registerValue = 16'h00A5;
    step();
    n = 0;
    while (busy && n < 1000) begin n++; step(); end
    check("busy_len", 48'(n), 48'(REPORT_CYCLES));
    steps(5);

    // Intermediate value dropped, latest reported.
    do_reset(2);
    registerValue = 16'h00A5;
    steps(20);
    registerValue = 16'h1234;
    steps(80);
    registerValue = 16'hBEEF;
    steps(2 * REPORT_CYCLES + 20);

    // Change and change back while busy: no further report.
    registerValue = 16'h00A5;
    steps(50);
    registerValue = 16'h0001;
    steps(30);
    registerValue = 16'h00A5;
    steps(REPORT_CYCLES + 100);

    // Reset in the middle of a report, then the same value resent in full.
    registerValue = 16'hBEEF;
    steps(120);
    do_reset(3);
    steps(REPORT_CYCLES + 20);

    // Randomized value stream.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: v = '0;
        1: v = m_last;
        2: v = 16'h00A5;
        3: v = 16'($urandom);
        default: v = registerValue ^ 16'h0100;
      endcase
      registerValue = v;
      steps(int'($urandom_range(1, 300)));
    end
    wait_idle();

    // Count wrap.
    force dut.r_report_count = 16'hFFFF;
    #1 release dut.r_report_count;
    m_count = 16'hFFFF;
    registerValue = m_last ^ 16'h0F0F;
    step();
    wait_idle();
    check("wrap", {32'b0, reportCount}, 48'd0);

    steps(50);
    check("pending_reports", 48'(exp_q.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_reporter.md
REGISTER_REPORTER -- requirements
Module: register_reporter

Interface
REQ-001: Parameter REGISTER_WIDTH, default 32: width of the monitored CPU register value; SHALL be a multiple of 4, minimum 4.
REQ-002: Parameter CLOCKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200); minimum 2.
REQ-003: clock  input  1  single system clock; all state updates on its rising edge.
REQ-004: isReset  input  1  asynchronous, active-high reset.
REQ-005: registerValue  input  REGISTER_WIDTH  CPU register1Value, consumed directly; synchronous to clock.
REQ-006: txd  output  1  UART transmit line, 8N1, idle high; registered.
REQ-007: busy  output  1  high while a report is being transmitted; registered.
REQ-008: reportCount  output  16  number of completed reports, wraps 0xFFFF -> 0x0000.

Function
REQ-009: Block SHALL hold lastSent (REGISTER_WIDTH), snapshot (REGISTER_WIDTH), a bit-timer counter, a bit index, a character index and a state register.
REQ-010: States SHALL be IDLE, START, DATA, STOP.
REQ-011: IDLE: on a rising edge where registerValue != lastSent, SHALL load snapshot and lastSent with registerValue, clear the character index, enter START, drive txd=0 and busy=1 from that same edge.
REQ-012: IDLE with registerValue == lastSent: SHALL remain IDLE, txd=1, busy=0.
REQ-013: A report SHALL be REGISTER_WIDTH/4 hex characters of snapshot, most significant nibble first, then CR (0x0D), then LF (0x0A).
REQ-014: Nibble 0-9 SHALL encode as 0x30-0x39; nibble A-F as uppercase 0x41-0x46.
REQ-015: Each character frame SHALL be start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLOCKS_PER_BIT cycles.
REQ-016: START -> DATA after CLOCKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP -> START of next character with no idle gap, or -> IDLE after the LF stop bit.
REQ-017: Total report duration SHALL be (REGISTER_WIDTH/4 + 2) x 10 x CLOCKS_PER_BIT cycles from the txd falling edge to the return to IDLE.
REQ-018: reportCount SHALL increment on the edge that enters IDLE after the LF stop bit; busy SHALL fall on that same edge.
REQ-019: registerValue changes while busy SHALL NOT alter the frame in progress (snapshot frozen).
REQ-020: On return to IDLE, the next edge SHALL compare the current registerValue against lastSent; only the latest value is reported, intermediate values are dropped.
REQ-021: A new report SHALL start no earlier than the first edge after the IDLE entry edge (minimum one idle-high cycle between reports).
REQ-022: registerValue equal to lastSent at the IDLE check (including a value that changed and changed back while busy) SHALL NOT trigger a report.

Reset
REQ-023: isReset high SHALL immediately, without a clock edge, force state=IDLE, txd=1, busy=0, reportCount=0, lastSent=0, snapshot=0, all counters 0.
REQ-024: Reset asserted mid-report SHALL abort the frame with txd high; no partial report counted.
REQ-025: After reset release, a registerValue of 0 SHALL NOT be reported; any nonzero value SHALL be reported per REQ-011 on the first edge it is sampled.

Verification (bench: REGISTER_WIDTH=16, CLOCKS_PER_BIT=4)
REQ-026: Assert isReset mid-cycle -> txd=1, busy=0, reportCount=0 before next clock edge; hold registerValue=0 for 500 cycles after release -> txd stays 1, reportCount=0.
REQ-027: registerValue=0x00A5 -> bytes 0x30,0x30,0x41,0x35,0x0D,0x0A decoded; busy high exactly 240 cycles; reportCount=1.
REQ-028: registerValue=0x00A5, then 0x1234 at cycle 20, 0xBEEF at cycle 100 -> first report "00A5", second "BEEF", "1234" never sent; reportCount=2; >=1 idle-high cycle between reports.
REQ-029: lastSent=0x00A5; change to 0x0001 then back to 0x00A5 during report -> no report; reportCount unchanged, txd=1.
REQ-030: Assert isReset at cycle 120 of a 0xBEEF report, release, keep 0xBEEF -> txd high during reset, reportCount=0, then full "BEEF" CR LF resent, reportCount=1.
REQ-031: Preload reportCount to 0xFFFF via 65535 reports (or force), one more report -> reportCount=0x0000.
